// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Upper bound on MAX_LEN / CNT_W; users truncate to their own width.
  localparam int MASK_W = 32;

  localparam logic [MASK_W-1:0] CNT_MAX = '1;

  // Ones in bit positions [len-1:0], zeros above.
  function automatic logic [MASK_W-1:0] len_mask(input int len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Config, serial stream and status bundle for seq_pattern_detector.
interface seq_pattern_detector_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
);

  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               sequence_in;
  logic               detector_out;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic               active;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, sequence_in,
    input  detector_out, match_count, cfg_err, active
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, sequence_in,
    output detector_out, match_count, cfg_err, active
  );

endinterface

// File: rtl/seq_det_hist.sv
// Serial history shift register with a saturating count of valid bits held.
module seq_det_hist #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               shift,
  input  logic               bit_in,
  output logic [MAX_LEN-1:0] hist,
  output logic [LEN_W-1:0]   fill
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = MAX_LEN'({hist_q, bit_in});
      if (fill_q != LEN_W'(MAX_LEN)) fill_d = fill_q + LEN_W'(1);
    end
  end

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist = hist_q;
  assign fill = fill_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with a registered match strobe
// and a saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  seq_pattern_detector_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               det_q, det_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] hist, hist_next, mask;
  logic [LEN_W-1:0]   fill;
  logic               cfg_legal, sample, fill_ok, match;

  assign cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
  // A config load in the same cycle drops the incoming bit.
  assign sample    = (state_q == RUN) && bus.in_valid && !bus.cfg_load;
  assign hist_next = MAX_LEN'({hist, bus.sequence_in});
  assign mask      = MAX_LEN'(len_mask(int'(len_q)));
  assign fill_ok   = ((LEN_W+1)'(fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);
  assign match     = sample && fill_ok && (((hist_next ^ pattern_q) & mask) == '0);

  // Without overlap a match empties the history so its bits cannot be reused.
  seq_det_hist #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clock  (clock),
    .reset  (reset),
    .clr    (bus.cfg_load || (match && !overlap_q)),
    .shift  (sample),
    .bit_in (bus.sequence_in),
    .hist   (hist),
    .fill   (fill)
  );

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    det_d     = 1'b0;

    case (state_q)
      IDLE: ;
      RUN: begin
        if (match) begin
          det_d = 1'b1;
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.cfg_load) begin
      cnt_d = '0;
      det_d = 1'b0;
      if (cfg_legal) begin
        state_d   = RUN;
        err_d     = 1'b0;
        pattern_d = bus.cfg_pattern;
        len_d     = bus.cfg_len;
        overlap_d = bus.cfg_overlap;
      end else begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      det_q     <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      det_q     <= det_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.detector_out = det_q;
  assign bus.match_count  = cnt_q;
  assign bus.cfg_err      = err_q;
  assign bus.active       = (state_q == RUN);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based reference model of the detector.
module tb_seq_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic clock;
  logic reset;

  seq_pattern_detector_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) bif ();
  seq_pattern_detector_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) bif_s ();

  seq_pattern_detector #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  seq_pattern_detector #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut_s (
    .clock (clock),
    .reset (reset),
    .bus   (bif_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: the bits seen since the last clear, newest at the back.
  int       m_q[$];
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl, m_run, m_det, m_err;
  int       m_cnt;

  task automatic model_reset();
    m_q.delete();
    m_pat = '0; m_len = 0; m_ovl = 0;
    m_run = 0;  m_det = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit load, input bit [7:0] p, input int l,
                            input bit o, input bit v, input bit b);
    bit hit;
    m_det = 0;
    if (load) begin
      m_q.delete();
      m_cnt = 0;
      if (l >= 1 && l <= MAX_LEN) begin
        m_run = 1; m_err = 0; m_pat = p; m_len = l; m_ovl = o;
      end else begin
        m_run = 0; m_err = 1;
      end
    end else if (m_run && v) begin
      m_q.push_back(int'(b));
      if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
      hit = (m_q.size() >= m_len);
      for (int i = 0; i < m_len && hit; i++)
        if (m_q[m_q.size()-1-i] != int'(m_pat[i])) hit = 0;
      if (hit) begin
        m_det = 1;
        if (m_cnt < 255) m_cnt++;
        if (!m_ovl) m_q.delete();
      end
    end
  endtask

  // One clock on the main DUT; the saturation DUT is held idle.
  task automatic cycle(input bit load, input bit [7:0] p, input int l,
                       input bit o, input bit v, input bit b);
    @(negedge clock);
    bif.cfg_load    = load;
    bif.cfg_pattern = p;
    bif.cfg_len     = LEN_W'(l);
    bif.cfg_overlap = o;
    bif.in_valid    = v;
    bif.sequence_in = b;
    bif_s.cfg_load  = 1'b0;
    bif_s.in_valid  = 1'b0;
    @(posedge clock);
    #1;
    model_step(load, p, l, o, v, b);
  endtask

  task automatic cycle_s(input bit load, input bit [7:0] p, input int l,
                         input bit o, input bit v, input bit b);
    @(negedge clock);
    bif_s.cfg_load    = load;
    bif_s.cfg_pattern = p;
    bif_s.cfg_len     = LEN_W'(l);
    bif_s.cfg_overlap = o;
    bif_s.in_valid    = v;
    bif_s.sequence_in = b;
    bif.cfg_load      = 1'b0;
    bif.in_valid      = 1'b0;
    @(posedge clock);
    #1;
    model_step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    checks++; if (bif.detector_out !== 1'b0) begin errors++; $display("FAIL reset_det got %b exp 0", bif.detector_out); end
    checks++; if (bif.match_count !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bif.match_count); end
    checks++; if (bif.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bif.cfg_err); end
    checks++; if (bif.active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", bif.active); end
    checks++; if (bif_s.match_count !== 2'd0) begin errors++; $display("FAIL reset_cnt_s got %0d exp 0", bif_s.match_count); end
  endtask

  task automatic run_stream(input string name, input bit [6:0] bits, input bit [6:0] pulses);
    for (int i = 0; i < 7; i++) begin
      cycle(0, 8'h00, 0, 0, 1, bits[6-i]);
      checks++;
      if (bif.detector_out !== m_det || m_det !== pulses[6-i]) begin
        errors++;
        $display("FAIL %s_det bit%0d got %b exp %b", name, i + 1, bif.detector_out, pulses[6-i]);
      end
    end
  endtask

  task automatic test_overlap();
    cycle(1, 8'h0B, 4, 1, 0, 0);
    checks++; if (bif.active !== 1'b1) begin errors++; $display("FAIL ovl_active got %b exp 1", bif.active); end
    run_stream("ovl", 7'b1011011, 7'b0001001);
    checks++; if (bif.match_count !== 8'd2) begin errors++; $display("FAIL ovl_cnt got %0d exp 2", bif.match_count); end
  endtask

  task automatic test_no_overlap();
    cycle(1, 8'h0B, 4, 0, 0, 0);
    checks++; if (bif.match_count !== 8'd0) begin errors++; $display("FAIL novl_cnt_clr got %0d exp 0", bif.match_count); end
    run_stream("novl", 7'b1011011, 7'b0001000);
    checks++; if (bif.match_count !== 8'd1) begin errors++; $display("FAIL novl_cnt got %0d exp 1", bif.match_count); end
  endtask

  task automatic test_gaps();
    bit [2:0] s = 3'b101;
    cycle(1, 8'hF5, 3, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 8'h00, 0, 0, 1, s[2-i]);
      checks++;
      if (bif.detector_out !== m_det || m_det !== (i == 2)) begin
        errors++; $display("FAIL gap_det bit%0d got %b exp %b", i + 1, bif.detector_out, m_det);
      end
      for (int g = 0; g < 5; g++) begin
        cycle(0, 8'h00, 0, 0, 0, 1);
        checks++;
        if (bif.detector_out !== 1'b0) begin
          errors++; $display("FAIL gap_idle bit%0d gap%0d got %b exp 0", i + 1, g, bif.detector_out);
        end
      end
    end
    checks++; if (bif.match_count !== 8'd1) begin errors++; $display("FAIL gap_cnt got %0d exp 1", bif.match_count); end
  endtask

  task automatic test_illegal();
    int lens[2] = '{0, MAX_LEN + 1};
    foreach (lens[k]) begin
      cycle(1, 8'hFF, lens[k], 1, 0, 0);
      checks++; if (bif.cfg_err !== 1'b1) begin errors++; $display("FAIL ill_err len%0d got %b exp 1", lens[k], bif.cfg_err); end
      checks++; if (bif.active !== 1'b0) begin errors++; $display("FAIL ill_active len%0d got %b exp 0", lens[k], bif.active); end
      for (int i = 0; i < 10; i++) begin
        cycle(0, 8'h00, 0, 0, 1, 1'($urandom_range(0, 1)));
        checks++;
        if (bif.detector_out !== 1'b0) begin errors++; $display("FAIL ill_det len%0d cyc%0d got %b exp 0", lens[k], i, bif.detector_out); end
      end
    end
    cycle(1, 8'h03, 2, 1, 0, 0);
    checks++; if (bif.cfg_err !== 1'b0) begin errors++; $display("FAIL legal_err got %b exp 0", bif.cfg_err); end
    checks++; if (bif.active !== 1'b1) begin errors++; $display("FAIL legal_active got %b exp 1", bif.active); end
  endtask

  task automatic test_collision();
    cycle(1, 8'h0B, 4, 1, 0, 0);
    cycle(0, 8'h00, 0, 0, 1, 1);
    cycle(0, 8'h00, 0, 0, 1, 0);
    cycle(0, 8'h00, 0, 0, 1, 1);
    cycle(1, 8'h0B, 4, 1, 1, 1);
    checks++; if (bif.detector_out !== 1'b0) begin errors++; $display("FAIL coll_det got %b exp 0", bif.detector_out); end
    checks++; if (bif.match_count !== 8'd0) begin errors++; $display("FAIL coll_cnt got %0d exp 0", bif.match_count); end
    run_stream("coll_after", 7'b1011000, 7'b0001000);
  endtask

  task automatic test_saturation();
    cycle_s(1, 8'h01, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle_s(0, 8'h00, 0, 0, 1, 1);
      checks++;
      if (bif_s.detector_out !== 1'b1) begin errors++; $display("FAIL sat_det bit%0d got %b exp 1", i + 1, bif_s.detector_out); end
      checks++;
      if (bif_s.match_count !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
        errors++; $display("FAIL sat_cnt bit%0d got %0d exp %0d", i + 1, bif_s.match_count, (i + 1 > 3) ? 3 : i + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit [2:0] s = 3'b101;
    cycle(1, 8'h0B, 4, 0, 0, 0);
    run_stream("pre_rst", 7'b1011101, 7'b0001000);
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++; if (bif.match_count !== 8'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d exp 0", bif.match_count); end
    checks++; if (bif.active !== 1'b0) begin errors++; $display("FAIL rst_mid_active got %b exp 0", bif.active); end
    checks++; if (bif.detector_out !== 1'b0) begin errors++; $display("FAIL rst_mid_det got %b exp 0", bif.detector_out); end
    @(negedge clock);
    reset = 1'b0;
    cycle(0, 8'h00, 0, 0, 1, 1);
    checks++; if (bif.detector_out !== 1'b0) begin errors++; $display("FAIL rst_after_det got %b exp 0", bif.detector_out); end
    checks++; if (bif.active !== 1'b0) begin errors++; $display("FAIL rst_after_active got %b exp 0", bif.active); end
    if (s == 3'b000) $display("unused");
  endtask

  task automatic test_random();
    cycle(1, 8'($urandom), 2, 1, 0, 0);
    for (int n = 0; n < 600; n++) begin
      bit load = ($urandom_range(0, 24) == 0);
      int l    = $urandom_range(0, 10);
      if ($urandom_range(0, 3) != 0) l = $urandom_range(1, 4);
      cycle(load, 8'($urandom), l, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
      checks++;
      if (bif.detector_out !== m_det) begin errors++; $display("FAIL rnd_det cyc%0d got %b exp %b", n, bif.detector_out, m_det); end
      checks++;
      if (bif.match_count !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_cnt cyc%0d got %0d exp %0d", n, bif.match_count, m_cnt); end
      checks++;
      if (bif.cfg_err !== m_err || bif.active !== m_run) begin
        errors++; $display("FAIL rnd_status cyc%0d got err=%b act=%b exp err=%b act=%b", n, bif.cfg_err, bif.active, m_err, m_run);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bif.cfg_load = 0; bif.cfg_pattern = '0; bif.cfg_len = '0; bif.cfg_overlap = 0;
    bif.in_valid = 0; bif.sequence_in = 0;
    bif_s.cfg_load = 0; bif_s.cfg_pattern = '0; bif_s.cfg_len = '0; bif_s.cfg_overlap = 0;
    bif_s.in_valid = 0; bif_s.sequence_in = 0;
    model_reset();
    repeat (2) @(negedge clock);
    test_reset();
    reset = 1'b0;
    test_overlap();
    test_no_overlap();
    test_gaps();
    test_illegal();
    test_collision();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised successor to the fixed 5-state Moore sequence detector.
- Detects a runtime-programmable serial bit pattern of length 1..MAX_LEN.
- Supports overlapping and non-overlapping detection, a valid qualifier on the input stream, and a saturating match counter.
- Sits on a serial bit stream in front of control logic that needs a registered one-cycle detection strobe.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1): width of the length field.
- CNT_W, 8: width of the saturating match counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- cfg_load  input  1  1-cycle strobe; latches the cfg_* fields and restarts the search.
- cfg_pattern  input  MAX_LEN  pattern. Bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len  input  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- in_valid  input  1  sequence_in is sampled only when this is 1.
- sequence_in  input  1  serial data bit.
- detector_out  output  1  registered match strobe (Moore: depends only on state).
- match_count  output  CNT_W  saturating count of matches since the last cfg_load.
- cfg_err  output  1  the last cfg_load had an illegal cfg_len.
- active  output  1  detector is in RUN.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears these to 0: state (IDLE), pattern, len, overlap, history, fill, detector_out, match_count, cfg_err.
  - active = 0.
  - Reset asserted mid-operation aborts immediately; no strobe is emitted after release.
- State machine, 2 states:
  - IDLE: ignores in_valid and sequence_in; detector_out = 0.
  - cfg_load with 1 <= cfg_len <= MAX_LEN: move to RUN, set cfg_err = 0.
  - cfg_load with cfg_len = 0 or > MAX_LEN: stay in or go to IDLE, set cfg_err = 1.
  - RUN: search. A legal cfg_load re-latches the config. An illegal cfg_load drops to IDLE.
- Every cfg_load, legal or not:
  - clears history, fill and match_count;
  - clears detector_out at the next edge.
- History update: on each RUN cycle with in_valid = 1,
  - hist_next = {hist[MAX_LEN-2:0], sequence_in};
  - fill saturates at MAX_LEN.
- Match condition (same cycle):
  - (fill+1) >= len, and
  - hist_next[len-1:0] == pattern[len-1:0], compared under a mask built from len.
- Output timing:
  - detector_out = 1 in the cycle after the edge that sampled the completing bit (one-cycle latency).
  - Exactly one cycle wide per match.
  - Otherwise detector_out = 0, including all cycles with in_valid = 0.
- Overlap handling:
  - cfg_overlap = 1: history is kept after a match.
  - cfg_overlap = 0: on a match, fill is forced to 0 so the matching bits cannot be reused.
- match_count: increments on each match and saturates at all-ones (no wrap).
- Priority:
  - cfg_load in the same cycle as in_valid: cfg_load wins and the bit is dropped.
  - reset overrides everything.
- in_valid gaps: do not disturb history; the pattern may span gaps of any length.
- cfg_* inputs are don't-care except in cycles where cfg_load = 1.

Decomposition:
- Package seq_det_pkg holds:
  - the state enum typedef (IDLE, RUN);
  - the function len_mask(len) returning a MAX_LEN-bit mask;
  - the localparam CNT_MAX.
- One sub-module, seq_det_hist: the history shift register plus fill counter, with ports clock, reset, clr, shift, bit_in, hist, fill.
- The FSM, compare logic and counter stay in the top.

Test Plan:
1. Overlap on: pattern=4'b1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 (continuous valid).
   - detector_out pulses after bit 4 and after bit 7.
   - match_count = 2.
2. Overlap off: same pattern and stream as scenario 1 with overlap=0.
   - Single pulse, after bit 4 only.
   - match_count = 1.
3. Valid gaps: len=3, pattern=3'b101; stream 1,0,1 with in_valid low for 5 cycles between each bit.
   - One pulse, exactly one cycle after the third sampled bit.
   - detector_out = 0 in every idle cycle.
4. Illegal config: cfg_len=0, then cfg_len=MAX_LEN+1.
   - cfg_err = 1, active = 0, no pulses for any stream.
   - A following legal load clears cfg_err and sets active = 1.
5. Collision and saturation:
   - cfg_load in the same cycle as a pattern-completing bit → no pulse, match_count = 0.
   - CNT_W=2, pattern=1'b1, len=1, overlap=1, five 1s → match_count sticks at 3.
6. Reset mid-operation: assert reset after 3 of 4 pattern bits, then release.
   - Outputs go to 0 immediately; active = 0.
   - Feeding the 4th bit produces no pulse.
